seq_loop_profiler: RTL and testbench
====================================

# seq_loop_profiler

Synthesizable, parametrised successor of the testbench loop-status monitor: watches a kernel's one-hot `ap_CS_fsm` and profiles up to `NUM_LOOPS` sequential loops in hardware. Per loop it records iteration count, last/min/max iteration latency and total in-loop cycles, plus kernel transaction count. It sits beside the HLS kernel top, taps the FSM and block-level handshake, and exposes results through a registered indexed read port for a debug/AXI-Lite wrapper.

## Interface
- `STATE_W`, 76: width of the one-hot FSM vector.
- `NUM_LOOPS`, 4: number of independently profiled loops (≥1).
- `CNT_W`, 32: width of every counter/statistic.
- `SEL_W`, `$clog2(NUM_LOOPS)` (min 1): loop-select width.

- `ap_clk`  in  1  clock; all logic on rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `ap_start`  in  1  kernel start (observed only).
- `ap_done`  in  1  kernel done pulse (observed only).
- `cur_state`  in  STATE_W  kernel `ap_CS_fsm`, one-hot.
- `iter_start_mask`  in  NUM_LOOPS*STATE_W  loop i, slice i: states that begin an iteration.
- `iter_end_mask`  in  NUM_LOOPS*STATE_W  states that end an iteration.
- `quit_mask`  in  NUM_LOOPS*STATE_W  states that exit the loop.
- `clr`  in  1  synchronous clear of all statistics.
- `rd_sel`  in  SEL_W  loop to read.
- `rd_field`  in  3  field to read.
- `rd_data`  out  CNT_W  registered read data.
- `busy`  out  1  high between `ap_start` accepted and `ap_done`.
- `err`  out  NUM_LOOPS  sticky per-loop protocol error.

## Operation
- Per loop i, per cycle: `s_hit`=|(cur_state & start_i), `e_hit`=|(cur_state & end_i), `q_hit`=|(cur_state & quit_i).
- Loop FSM states: IDLE, ITER, GAP.
  - IDLE: `s_hit` → ITER, `lat`=1. If `e_hit` same cycle, iteration completes (latency 1), → GAP.
  - ITER: `lat`+1 each cycle; `e_hit` → complete iteration, → GAP. `q_hit` (no `e_hit`) → abort: iteration not counted, `err[i]` set, → IDLE. `s_hit` without `e_hit` → restart: not counted, `err[i]` set, `lat`=1, stay ITER.
  - GAP: `s_hit` → ITER (`lat`=1; `s_hit&e_hit` completes a 1-cycle iteration, stays GAP). `q_hit` → IDLE.
- One-state loops (start=end=same state): every cycle in that state is one 1-cycle iteration.
- On completion: `iter_cnt`+1, `last_lat`=`lat` (including the end cycle), min/max updated.
- `loop_cyc` +1 every cycle loop FSM is ITER or GAP.
- `trans_cnt` +1 per `ap_done` cycle; `busy` set on `ap_start` while not busy, cleared on `ap_done` (done wins if both).
- All counters saturate at all-ones; never wrap.
- `clr` resets stats, FSMs to IDLE, `err`=0, `busy` unaffected; `clr` beats every simultaneous event.
- `rd_field`: 0 `iter_cnt`, 1 `last_lat`, 2 `min_lat`, 3 `max_lat`, 4 `loop_cyc`, 5 `trans_cnt` (ignores `rd_sel`), 6 status {…0, err[i], fsm[1:0]}, 7 zero. `rd_sel` ≥ NUM_LOOPS reads zero.

## Timing
- Reset (async assert, sync-to-edge release): `rd_data`=0, `busy`=0, `err`=0, all FSMs IDLE, counters 0, `min_lat`=all-ones.
- Stats reflect an event on cycle t from cycle t+1.
- Read latency 1: `rd_data` at edge t+1 reflects `rd_sel`/`rd_field` and state sampled at edge t.
- No backpressure; block never stalls the kernel.
- Non-one-hot `cur_state` is not checked; masking applies bitwise.

## Configuration
- `SEQ_LOOP_PROF_MINMAX_EN`: defined → min/max latency registers and comparators built, fields 2/3 valid. Undefined → logic removed, fields 2/3 read 0, `min_lat` reset value irrelevant.

## Test plan
- Loop 0 start=bit1, end=bit75, quit=bit0 (76-state FSM); 3 stall-free passes then quit → `iter_cnt`=3, `last_lat`=75, min=max=75, `loop_cyc`=225.
- One-state loop start=end=bit5, FSM holds bit5 for 10 cycles then exits to quit bit6 → `iter_cnt`=10, `last_lat`=1.
- Quit mid-iteration after 4 cycles → `iter_cnt` unchanged, `err[0]`=1, status fsm=IDLE; `clr` → `err`=0, counters 0.
- CNT_W=4, 20 one-cycle iterations → `iter_cnt`=15 (saturated); `ap_done` ×3 → `trans_cnt`=3.
- Assert `ap_rst_n`=0 mid-ITER asynchronously → `rd_data`, `busy`, `err` 0 before next edge; with macro undefined, field 2 reads 0.

Source files
------------

// File: rtl/seq_loop_profiler.sv
// seq_loop_profiler
// Taps a kernel's one-hot ap_CS_fsm and block handshake and profiles up to
// NUM_LOOPS sequential loops: iteration count, last/min/max iteration latency,
// total in-loop cycles, plus a kernel transaction count. Every counter
// saturates at all-ones.
//
// Optional feature macro: SEQ_LOOP_PROF_MINMAX_EN
//   defined   -> min/max latency registers built, rd_field 2/3 valid
//   undefined -> no min/max logic, rd_field 2/3 read zero
//
// Ports
//   ap_clk, ap_rst_n       clock, asynchronous active-low reset
//   ap_start, ap_done      kernel handshake (observed only)
//   cur_state              kernel FSM vector (one-hot)
//   iter_start_mask        slice i: states that begin an iteration of loop i
//   iter_end_mask          slice i: states that end an iteration of loop i
//   quit_mask              slice i: states that exit loop i
//   clr                    synchronous clear of all statistics and loop FSMs
//   rd_sel, rd_field       read select (loop, field)
//   rd_data                registered read data, one cycle latency
//   busy                   high between accepted ap_start and ap_done
//   err                    sticky per-loop protocol error
//
// rd_field: 0 iter_cnt, 1 last_lat, 2 min_lat, 3 max_lat, 4 loop_cyc,
//           5 trans_cnt (ignores rd_sel), 6 status {err, fsm[1:0]}, 7 zero.
// Status fsm code: 0 IDLE, 1 ITER, 2 GAP.
module seq_loop_profiler #(
  parameter int STATE_W   = 76,
  parameter int NUM_LOOPS = 4,
  parameter int CNT_W     = 32,
  parameter int SEL_W     = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  input  logic                         ap_done,
  input  logic [STATE_W-1:0]           cur_state,
  input  logic [NUM_LOOPS*STATE_W-1:0] iter_start_mask,
  input  logic [NUM_LOOPS*STATE_W-1:0] iter_end_mask,
  input  logic [NUM_LOOPS*STATE_W-1:0] quit_mask,
  input  logic                         clr,
  input  logic [SEL_W-1:0]             rd_sel,
  input  logic [2:0]                   rd_field,
  output logic [CNT_W-1:0]             rd_data,
  output logic                         busy,
  output logic [NUM_LOOPS-1:0]         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    GAP  = 2'd2
  } loop_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [NUM_LOOPS-1:0] s_hit, e_hit, q_hit;

  loop_state_t      state_q [NUM_LOOPS];
  loop_state_t      state_d [NUM_LOOPS];
  logic [CNT_W-1:0] lat_q   [NUM_LOOPS];
  logic [CNT_W-1:0] lat_d   [NUM_LOOPS];
  logic [CNT_W-1:0] cpl_lat [NUM_LOOPS];
  logic [NUM_LOOPS-1:0] cpl, err_set;

  logic [CNT_W-1:0] iter_cnt [NUM_LOOPS];
  logic [CNT_W-1:0] last_lat [NUM_LOOPS];
  logic [CNT_W-1:0] loop_cyc [NUM_LOOPS];
`ifdef SEQ_LOOP_PROF_MINMAX_EN
  logic [CNT_W-1:0] min_lat  [NUM_LOOPS];
  logic [CNT_W-1:0] max_lat  [NUM_LOOPS];
`endif
  logic [CNT_W-1:0]     trans_cnt;
  logic [NUM_LOOPS-1:0] err_q;
  logic [CNT_W-1:0]     rd_next;
  logic                 sel_ok;

  // Mask decode: masking is purely bitwise, so a non-one-hot state vector
  // simply hits every mask it overlaps.
  always_comb begin
    s_hit = '0;
    e_hit = '0;
    q_hit = '0;
    for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
      s_hit[i] = |(cur_state & iter_start_mask[i*STATE_W +: STATE_W]);
      e_hit[i] = |(cur_state & iter_end_mask[i*STATE_W +: STATE_W]);
      q_hit[i] = |(cur_state & quit_mask[i*STATE_W +: STATE_W]);
    end
  end

  // Loop FSM next-state. lat_q holds the cycles already spent in the
  // iteration, so a completion in ITER reports lat_q+1 to include the end cycle.
  always_comb begin
    cpl     = '0;
    err_set = '0;
    for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
      state_d[i] = state_q[i];
      lat_d[i]   = lat_q[i];
      cpl_lat[i] = CNT_W'(1);
      case (state_q[i])
        IDLE: begin
          if (s_hit[i]) begin
            lat_d[i] = CNT_W'(1);
            if (e_hit[i]) begin
              cpl[i]     = 1'b1;
              state_d[i] = GAP;
            end else begin
              state_d[i] = ITER;
            end
          end
        end
        ITER: begin
          if (e_hit[i]) begin
            cpl[i]     = 1'b1;
            cpl_lat[i] = sat_inc(lat_q[i]);
            state_d[i] = GAP;
          end else if (q_hit[i]) begin
            err_set[i] = 1'b1;
            state_d[i] = IDLE;
          end else if (s_hit[i]) begin
            err_set[i] = 1'b1;
            lat_d[i]   = CNT_W'(1);
          end else begin
            lat_d[i] = sat_inc(lat_q[i]);
          end
        end
        GAP: begin
          if (s_hit[i]) begin
            lat_d[i] = CNT_W'(1);
            if (e_hit[i]) cpl[i] = 1'b1;
            else          state_d[i] = ITER;
          end else if (q_hit[i]) begin
            state_d[i] = IDLE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
        state_q[i] <= IDLE;
        lat_q[i]   <= '0;
      end
    end else if (clr) begin
      for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
        state_q[i] <= IDLE;
        lat_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
    end
  end

  // Statistics; clr takes priority over every event in the same cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
        iter_cnt[i] <= '0;
        last_lat[i] <= '0;
        loop_cyc[i] <= '0;
`ifdef SEQ_LOOP_PROF_MINMAX_EN
        min_lat[i]  <= '1;
        max_lat[i]  <= '0;
`endif
      end
      err_q     <= '0;
      trans_cnt <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
        iter_cnt[i] <= '0;
        last_lat[i] <= '0;
        loop_cyc[i] <= '0;
`ifdef SEQ_LOOP_PROF_MINMAX_EN
        min_lat[i]  <= '1;
        max_lat[i]  <= '0;
`endif
      end
      err_q     <= '0;
      trans_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LOOPS; i++) begin
        if (cpl[i]) begin
          iter_cnt[i] <= sat_inc(iter_cnt[i]);
          last_lat[i] <= cpl_lat[i];
`ifdef SEQ_LOOP_PROF_MINMAX_EN
          if (cpl_lat[i] < min_lat[i]) min_lat[i] <= cpl_lat[i];
          if (cpl_lat[i] > max_lat[i]) max_lat[i] <= cpl_lat[i];
`endif
        end
        if (state_q[i] != IDLE) loop_cyc[i] <= sat_inc(loop_cyc[i]);
      end
      err_q <= err_q | err_set;
      if (ap_done) trans_cnt <= sat_inc(trans_cnt);
    end
  end

  // busy ignores clr; done wins over a simultaneous start.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)     busy <= 1'b0;
    else if (ap_done)  busy <= 1'b0;
    else if (ap_start) busy <= 1'b1;
  end

  always_comb begin
    rd_next = '0;
    sel_ok  = int'(rd_sel) < NUM_LOOPS;
    case (rd_field)
      3'd0: if (sel_ok) rd_next = iter_cnt[rd_sel];
      3'd1: if (sel_ok) rd_next = last_lat[rd_sel];
`ifdef SEQ_LOOP_PROF_MINMAX_EN
      3'd2: if (sel_ok) rd_next = min_lat[rd_sel];
      3'd3: if (sel_ok) rd_next = max_lat[rd_sel];
`endif
      3'd4: if (sel_ok) rd_next = loop_cyc[rd_sel];
      3'd5: rd_next = trans_cnt;
      3'd6: if (sel_ok) rd_next[2:0] = {err_q[rd_sel], state_q[rd_sel]};
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rd_data <= '0;
    else           rd_data <= rd_next;
  end

  assign err = err_q;

endmodule

// File: tb/tb_seq_loop_profiler.sv
module tb_seq_loop_profiler;
  localparam int SW = 76;
  localparam int NL = 4;
  localparam longint MAXB = 64'hFFFF_FFFF;
  localparam longint MAXS = 15;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic ap_start = 1'b0;
  logic ap_done = 1'b0;
  logic clr = 1'b0;
  logic [SW-1:0] cur_state = '0;
  logic [NL*SW-1:0] smask, emask, qmask;
  logic [1:0] rd_sel = 2'd0;
  logic [2:0] rd_field = 3'd0;
  logic [31:0] rd_b;
  logic [3:0]  rd_s;
  logic busy_b, busy_s;
  logic [NL-1:0] err_b, err_s;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  seq_loop_profiler #(.STATE_W(SW), .NUM_LOOPS(NL), .CNT_W(32)) u_big (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .cur_state(cur_state), .iter_start_mask(smask), .iter_end_mask(emask),
    .quit_mask(qmask), .clr(clr), .rd_sel(rd_sel), .rd_field(rd_field),
    .rd_data(rd_b), .busy(busy_b), .err(err_b));

  seq_loop_profiler #(.STATE_W(SW), .NUM_LOOPS(NL), .CNT_W(4)) u_small (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .cur_state(cur_state), .iter_start_mask(smask), .iter_end_mask(emask),
    .quit_mask(qmask), .clr(clr), .rd_sel(rd_sel), .rd_field(rd_field),
    .rd_data(rd_s), .busy(busy_s), .err(err_s));

  initial forever #5 ap_clk = ~ap_clk;

  // ---------------- behavioural model (unbounded counts, saturated on read)
  longint m_iter[NL], m_last[NL], m_min[NL], m_max[NL], m_cyc[NL], m_lat[NL];
  bit     m_in[NL], m_act[NL];
  bit [NL-1:0] m_err;
  longint m_trans;
  bit     m_busy;
  longint exp_b, exp_s;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit hit(input logic [NL*SW-1:0] m, input int l);
    return |(cur_state & m[l*SW +: SW]);
  endfunction

  function automatic longint rd_model(input int sel, input int fld, input longint mx);
    longint code;
    code = m_in[sel] ? (m_act[sel] ? 1 : 2) : 0;
    case (fld)
      0: return sat(m_iter[sel], mx);
      1: return sat(m_last[sel], mx);
`ifdef SEQ_LOOP_PROF_MINMAX_EN
      2: return sat(m_min[sel], mx);
      3: return sat(m_max[sel], mx);
`endif
      4: return sat(m_cyc[sel], mx);
      5: return sat(m_trans, mx);
      6: return longint'(m_err[sel]) * 4 + code;
      default: return 0;
    endcase
  endfunction

  task automatic model_clear();
    for (int l = 0; l < NL; l++) begin
      m_iter[l] = 0; m_last[l] = 0; m_min[l] = 64'h7FFF_FFFF_FFFF_FFFF;
      m_max[l] = 0; m_cyc[l] = 0; m_lat[l] = 0; m_in[l] = 0; m_act[l] = 0;
    end
    m_err = '0;
    m_trans = 0;
  endtask

  task automatic complete(input int l, input longint lat);
    m_iter[l]++;
    m_last[l] = lat;
    if (lat < m_min[l]) m_min[l] = lat;
    if (lat > m_max[l]) m_max[l] = lat;
  endtask

  initial begin
    model_clear();
    m_busy = 0; exp_b = 0; exp_s = 0;
  end

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      model_clear();
      m_busy = 0; exp_b = 0; exp_s = 0;
    end else begin
      exp_b = rd_model(int'(rd_sel), int'(rd_field), MAXB);
      exp_s = rd_model(int'(rd_sel), int'(rd_field), MAXS);
      if (ap_done) m_busy = 0;
      else if (ap_start) m_busy = 1;
      if (clr) model_clear();
      else begin
        if (ap_done) m_trans++;
        for (int l = 0; l < NL; l++) begin
          bit s, e, q;
          s = hit(smask, l); e = hit(emask, l); q = hit(qmask, l);
          if (m_in[l]) m_cyc[l]++;
          if (!m_in[l]) begin
            if (s) begin
              m_in[l] = 1; m_lat[l] = 1;
              if (e) complete(l, 1); else m_act[l] = 1;
            end
          end else if (m_act[l]) begin
            m_lat[l]++;                       // this cycle belongs to the iteration
            if (e) begin complete(l, m_lat[l]); m_act[l] = 0; end
            else if (q) begin m_err[l] = 1; m_in[l] = 0; m_act[l] = 0; end
            else if (s) begin m_err[l] = 1; m_lat[l] = 1; end
          end else begin
            if (s) begin
              m_lat[l] = 1;
              if (e) complete(l, 1); else m_act[l] = 1;
            end else if (q) m_in[l] = 0;
          end
        end
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle model comparison, sampled on the falling edge.
  always @(negedge ap_clk) begin
    if (chk_en && ap_rst_n) begin
      check("model_rd_big", longint'(rd_b), exp_b);
      check("model_rd_small", longint'(rd_s), exp_s);
      check("model_busy", longint'(busy_b), longint'(m_busy));
      check("model_busy_small", longint'(busy_s), longint'(m_busy));
      check("model_err", longint'(err_b), longint'(m_err));
      check("model_err_small", longint'(err_s), longint'(m_err));
    end
  end

  // ---------------- stimulus
  task automatic cyc(input int idx, input bit st, input bit dn, input bit cl);
    cur_state = '0;
    if (idx >= 0) cur_state[idx] = 1'b1;
    ap_start = st; ap_done = dn; clr = cl;
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic rd(input int sel, input int fld, input longint eb, input longint es,
                    input string nm);
    rd_sel = 2'(sel); rd_field = 3'(fld);
    cyc(-1, 0, 0, 0);
    check(nm, longint'(rd_b), eb);
    check({nm, "_small"}, longint'(rd_s), es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    smask = '0; emask = '0; qmask = '0;
    smask[0*SW+1] = 1'b1;  emask[0*SW+75] = 1'b1; qmask[0*SW+0] = 1'b1;
    smask[1*SW+5] = 1'b1;  emask[1*SW+5]  = 1'b1; qmask[1*SW+6] = 1'b1;
    smask[2*SW+40] = 1'b1; emask[2*SW+50] = 1'b1; qmask[2*SW+39] = 1'b1;
    smask[3*SW+60] = 1'b1; emask[3*SW+60] = 1'b1; qmask[3*SW+61] = 1'b1;

    repeat (3) @(negedge ap_clk);
    check("reset_rd", longint'(rd_b), 0);
    check("reset_busy", longint'(busy_b), 0);
    check("reset_err", longint'(err_b), 0);
    check("reset_rd_small", longint'(rd_s), 0);
    ap_rst_n = 1'b1;
    chk_en = 1'b1;

    // Three stall-free passes through the 76-state FSM, then quit.
    for (int p = 0; p < 3; p++)
      for (int b = 1; b <= 75; b++) cyc(b, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rd(0, 0, 3, 3, "pass_iter_cnt");
    rd(0, 1, 75, 15, "pass_last_lat");
`ifdef SEQ_LOOP_PROF_MINMAX_EN
    rd(0, 2, 75, 15, "pass_min_lat");
    rd(0, 3, 75, 15, "pass_max_lat");
`endif
    rd(0, 4, 225, 15, "pass_loop_cyc");
    cyc(-1, 0, 0, 1);

    // One-state loop: 10 cycles in bit5, then quit via bit6.
    for (int k = 0; k < 10; k++) cyc(5, 0, 0, 0);
    cyc(6, 0, 0, 0);
    rd(1, 0, 10, 10, "one_state_iter_cnt");
    rd(1, 1, 1, 1, "one_state_last_lat");
    rd(1, 4, 10, 10, "one_state_loop_cyc");
    cyc(-1, 0, 0, 1);

    // Quit mid-iteration after 4 cycles.
    for (int b = 1; b <= 4; b++) cyc(b, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rd(0, 0, 0, 0, "abort_iter_cnt");
    rd(0, 6, 4, 4, "abort_status");
    check("abort_err", longint'(err_b), 1);
    // Restart inside an iteration, then a completion of latency 2.
    cyc(1, 0, 0, 0); cyc(2, 0, 0, 0); cyc(1, 0, 0, 0); cyc(75, 0, 0, 0);
    rd(0, 0, 1, 1, "restart_iter_cnt");
    rd(0, 1, 2, 2, "restart_last_lat");
    rd(0, 6, 6, 6, "restart_status");
    cyc(-1, 0, 0, 1);
    check("clr_err", longint'(err_b), 0);
    rd(0, 0, 0, 0, "clr_iter_cnt");
    rd(0, 4, 0, 0, "clr_loop_cyc");

    // 20 one-cycle iterations: saturates the 4-bit instance.
    for (int k = 0; k < 20; k++) cyc(60, 0, 0, 0);
    cyc(61, 0, 0, 0);
    rd(3, 0, 20, 15, "sat_iter_cnt");
    cyc(-1, 1, 0, 0);
    check("busy_set", longint'(busy_b), 1);
    cyc(-1, 1, 1, 0);
    check("busy_done_wins", longint'(busy_b), 0);
    cyc(-1, 0, 1, 0);
    cyc(-1, 0, 1, 0);
    rd(2, 5, 3, 3, "trans_cnt");

    // Asynchronous reset in the middle of an iteration.
    cyc(-1, 1, 0, 0);
    cyc(1, 0, 0, 0); cyc(2, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(2, 0, 0, 0);
    rd_sel = 2'd0; rd_field = 3'd6;
    cyc(3, 0, 0, 0);
    check("pre_reset_rd", longint'(rd_b), 5);
    check("pre_reset_busy", longint'(busy_b), 1);
    check("pre_reset_err", longint'(err_b), 1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("async_rd", longint'(rd_b), 0);
    check("async_busy", longint'(busy_b), 0);
    check("async_err", longint'(err_b), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
`ifdef SEQ_LOOP_PROF_MINMAX_EN
    rd(0, 2, MAXB, 15, "reset_min_lat");
`else
    rd(0, 2, 0, 0, "field2_zero");
`endif
    rd(0, 6, 0, 0, "post_reset_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
